// File: rtl/vga_img_layer.sv
// Image overlay layer: maps screen coordinates onto a zoomed image ROM and emits RGB888 pixels.
// Optional colour keying is compiled in with `define IMG_COLORKEY_EN.
module vga_img_layer #(
  parameter int          IMG_W       = 256,
  parameter int          IMG_H       = 256,
  parameter int          AW          = 16,
  parameter int          PIX_FMT     = 0,
  parameter int          SCALE_SHIFT = 0,
  parameter int          ROM_LAT     = 1,
  parameter logic [23:0] BG_COLOR    = 24'h000000,
  localparam int         PIX_W       = (PIX_FMT == 0) ? 12 : (PIX_FMT == 1) ? 16 : 24
`ifdef IMG_COLORKEY_EN
  ,
  parameter logic [PIX_W-1:0] KEY_COLOR = '1
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [9:0]       h_addr,
  input  logic [9:0]       v_addr,
  input  logic             vsync,
  input  logic [9:0]       pos_x,
  input  logic [9:0]       pos_y,
  input  logic             pos_load,
  output logic             pos_pending,
  output logic [AW-1:0]    rom_addr,
  input  logic [PIX_W-1:0] rom_q,
  output logic [23:0]      pix_data,
  output logic             pix_hit
);

  localparam logic [10:0] WIN_W = 11'(IMG_W << SCALE_SHIFT);
  localparam logic [10:0] WIN_H = 11'(IMG_H << SCALE_SHIFT);

  logic               vsync_q;
  logic [9:0]         x0_q, y0_q, sx_q, sy_q;
  logic               pend_q;
  logic               vs_fall;

  assign vs_fall = vsync_q & ~vsync;

  // Origin changes only take effect on a frame boundary to avoid tearing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vsync_q <= 1'b1;
      x0_q    <= '0;
      y0_q    <= '0;
      sx_q    <= '0;
      sy_q    <= '0;
      pend_q  <= 1'b0;
    end else begin
      vsync_q <= vsync;
      if (vs_fall) begin
        if (pos_load) begin
          x0_q <= pos_x;
          y0_q <= pos_y;
          sx_q <= pos_x;
          sy_q <= pos_y;
        end else begin
          x0_q <= sx_q;
          y0_q <= sy_q;
        end
        pend_q <= 1'b0;
      end else if (pos_load) begin
        sx_q   <= pos_x;
        sy_q   <= pos_y;
        pend_q <= 1'b1;
      end
    end
  end

  assign pos_pending = pend_q;

  logic [10:0]   h_ext, v_ext, x_beg, y_beg, x_end, y_end;
  logic [9:0]    dx, dy;
  logic          win_d;
  logic [AW-1:0] rom_addr_d;

  always_comb begin
    h_ext      = {1'b0, h_addr};
    v_ext      = {1'b0, v_addr};
    x_beg      = {1'b0, x0_q};
    y_beg      = {1'b0, y0_q};
    x_end      = x_beg + WIN_W;
    y_end      = y_beg + WIN_H;
    win_d      = (h_ext >= x_beg) && (h_ext < x_end) && (v_ext >= y_beg) && (v_ext < y_end);
    dx         = 10'(h_addr - x0_q) >> SCALE_SHIFT;
    dy         = 10'(v_addr - y0_q) >> SCALE_SHIFT;
    rom_addr_d = '0;
    if (win_d)
      rom_addr_d = AW'(32'(dy) * 32'(IMG_W) + 32'(dx));
  end

  logic [AW-1:0]      rom_addr_q;
  logic               win_q;
  logic [ROM_LAT-1:0] win_dly_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rom_addr_q <= '0;
      win_q      <= 1'b0;
    end else begin
      rom_addr_q <= rom_addr_d;
      win_q      <= win_d;
    end
  end

  assign rom_addr = rom_addr_q;

  // Window flag travels alongside the ROM read so it lines up with rom_q.
  genvar gi;
  generate
    for (gi = 0; gi < ROM_LAT; gi++) begin : g_dly
      always_ff @(posedge clk or negedge reset) begin
        if (!reset)
          win_dly_q[gi] <= 1'b0;
        else if (gi == 0)
          win_dly_q[gi] <= win_q;
        else
          win_dly_q[gi] <= win_dly_q[(gi == 0) ? 0 : gi - 1];
      end
    end
  endgenerate

  logic [23:0] rgb;
  generate
    if (PIX_FMT == 0) begin : g_444
      assign rgb = {rom_q[11:8], rom_q[11:8], rom_q[7:4], rom_q[7:4], rom_q[3:0], rom_q[3:0]};
    end else if (PIX_FMT == 1) begin : g_565
      assign rgb = {rom_q[15:11], rom_q[15:13], rom_q[10:5], rom_q[10:9], rom_q[4:0], rom_q[4:2]};
    end else begin : g_888
      assign rgb = rom_q;
    end
  endgenerate

  logic keyed;
`ifdef IMG_COLORKEY_EN
  assign keyed = (rom_q == KEY_COLOR);
`else
  assign keyed = 1'b0;
`endif

  logic        hit_d;
  logic [23:0] pix_d;
  logic        hit_q;
  logic [23:0] pix_q;

  always_comb begin
    hit_d = win_dly_q[ROM_LAT-1] & ~keyed;
    pix_d = hit_d ? rgb : BG_COLOR;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pix_q <= BG_COLOR;
      hit_q <= 1'b0;
    end else begin
      pix_q <= pix_d;
      hit_q <= hit_d;
    end
  end

  assign pix_data = pix_q;
  assign pix_hit  = hit_q;

endmodule

// File: tb/tb_vga_img_layer.sv
// Directed bench for vga_img_layer: instance A (defaults, RGB444) and instance B
// (RGB565, 2x zoom, ROM latency 2, non-zero background) share the same raster inputs.
module tb_vga_img_layer;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  h_addr, v_addr, pos_x, pos_y;
  logic        vsync, pos_load;
  logic        frc;

  logic        a_pend, b_pend;
  logic [15:0] a_rom_addr, b_rom_addr;
  logic [11:0] a_rom_q;
  logic [15:0] b_rom_q, b_rom_p1;
  logic [23:0] a_pix, b_pix;
  logic        a_hit, b_hit;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  vga_img_layer #(
`ifdef IMG_COLORKEY_EN
    .KEY_COLOR(12'hFFF),
`endif
    .PIX_FMT(0)
  ) u_a (
    .clk(clk), .reset(reset), .h_addr(h_addr), .v_addr(v_addr), .vsync(vsync),
    .pos_x(pos_x), .pos_y(pos_y), .pos_load(pos_load), .pos_pending(a_pend),
    .rom_addr(a_rom_addr), .rom_q(a_rom_q), .pix_data(a_pix), .pix_hit(a_hit)
  );

  vga_img_layer #(
    .PIX_FMT(1), .SCALE_SHIFT(1), .ROM_LAT(2), .BG_COLOR(24'h123456)
  ) u_b (
    .clk(clk), .reset(reset), .h_addr(h_addr), .v_addr(v_addr), .vsync(vsync),
    .pos_x(pos_x), .pos_y(pos_y), .pos_load(pos_load), .pos_pending(b_pend),
    .rom_addr(b_rom_addr), .rom_q(b_rom_q), .pix_data(b_pix), .pix_hit(b_hit)
  );

  // ROM models: contents equal the low address bits, unless a forced word is selected.
  always @(posedge clk) begin
    a_rom_q  <= frc ? 12'hF80 : a_rom_addr[11:0];
    b_rom_p1 <= b_rom_addr;
    b_rom_q  <= frc ? 16'hF81F : b_rom_p1;
  end

  typedef struct {
    logic [9:0]  h;
    logic [9:0]  v;
    logic        f;
    logic [15:0] a_addr;
    logic [15:0] b_addr;
    logic        a_hit;
    logic        b_hit;
    logic [23:0] a_pix;
    logic [23:0] b_pix;
  } vec_t;

  vec_t vt[11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  logic [23:0] sp[4];

  initial begin
    vt[0]  = '{10'd5,   10'd2,   1'b0, 16'd517,   16'd258,   1'b1, 1'b1, 24'h220055, 24'h002010};
    vt[1]  = '{10'd0,   10'd0,   1'b0, 16'd0,     16'd0,     1'b1, 1'b1, 24'h000000, 24'h000000};
`ifdef IMG_COLORKEY_EN
    vt[2]  = '{10'd255, 10'd255, 1'b0, 16'd65535, 16'd32639, 1'b0, 1'b1, 24'h000000, 24'h7BEFFF};
`else
    vt[2]  = '{10'd255, 10'd255, 1'b0, 16'd65535, 16'd32639, 1'b1, 1'b1, 24'hFFFFFF, 24'h7BEFFF};
`endif
    vt[3]  = '{10'd256, 10'd10,  1'b0, 16'd0,     16'd1408,  1'b0, 1'b1, 24'h000000, 24'h00B200};
    vt[4]  = '{10'd10,  10'd256, 1'b0, 16'd0,     16'd32773, 1'b0, 1'b1, 24'h000000, 24'h840029};
    vt[5]  = '{10'd17,  10'd1,   1'b0, 16'd273,   16'd8,     1'b1, 1'b1, 24'h111111, 24'h000042};
    vt[6]  = '{10'd255, 10'd0,   1'b0, 16'd255,   16'd127,   1'b1, 1'b1, 24'h00FFFF, 24'h000CFF};
    vt[7]  = '{10'd639, 10'd479, 1'b0, 16'd0,     16'd0,     1'b0, 1'b0, 24'h000000, 24'h123456};
`ifdef IMG_COLORKEY_EN
    vt[8]  = '{10'd511, 10'd511, 1'b0, 16'd0,     16'd65535, 1'b0, 1'b0, 24'h000000, 24'h123456};
`else
    vt[8]  = '{10'd511, 10'd511, 1'b0, 16'd0,     16'd65535, 1'b0, 1'b1, 24'h000000, 24'hFFFFFF};
`endif
    vt[9]  = '{10'd512, 10'd0,   1'b0, 16'd0,     16'd0,     1'b0, 1'b0, 24'h000000, 24'h123456};
    vt[10] = '{10'd5,   10'd2,   1'b1, 16'd517,   16'd258,   1'b1, 1'b1, 24'hFF8800, 24'hFF00FF};
    sp[0] = 24'h000000; sp[1] = 24'h000011; sp[2] = 24'h000022; sp[3] = 24'h000033;

    reset = 1'b0; vsync = 1'b1; pos_load = 1'b0; pos_x = '0; pos_y = '0;
    h_addr = '0; v_addr = '0; frc = 1'b0;
    repeat (3) tick();
    chk("rst_a_pix",  32'(a_pix), 32'h000000);
    chk("rst_a_hit",  32'(a_hit), 32'd0);
    chk("rst_b_pix",  32'(b_pix), 32'h123456);
    chk("rst_a_addr", 32'(a_rom_addr), 32'd0);
    chk("rst_a_pend", 32'(a_pend), 32'd0);
    reset = 1'b1;
    tick();

    // Table: origin (0,0), each vector held until both pipelines have flushed.
    for (int i = 0; i < 11; i++) begin
      h_addr = vt[i].h; v_addr = vt[i].v; frc = vt[i].f;
      tick();
      chk("a_rom_addr", 32'(a_rom_addr), 32'(vt[i].a_addr));
      chk("b_rom_addr", 32'(b_rom_addr), 32'(vt[i].b_addr));
      tick(); tick();
      chk("a_pix", 32'(a_pix), 32'(vt[i].a_pix));
      chk("a_hit", 32'(a_hit), 32'(vt[i].a_hit));
      tick();
      chk("b_pix", 32'(b_pix), 32'(vt[i].b_pix));
      chk("b_hit", 32'(b_hit), 32'(vt[i].b_hit));
      $display("vec %0d h=%0d v=%0d a_addr=%0d a_pix=%h/%0d b_addr=%0d b_pix=%h/%0d",
               i, vt[i].h, vt[i].v, a_rom_addr, a_pix, a_hit, b_rom_addr, b_pix, b_hit);
    end
    frc = 1'b0;

    // Deferred origin load: old origin stays in effect until vsync falls.
    pos_x = 10'd100; pos_y = 10'd50; pos_load = 1'b1;
    tick();
    pos_load = 1'b0;
    chk("load_a_pend", 32'(a_pend), 32'd1);
    chk("load_b_pend", 32'(b_pend), 32'd1);
    h_addr = 10'd100; v_addr = 10'd50;
    tick();
    chk("old_org_a_addr", 32'(a_rom_addr), 32'd12900);
    chk("old_org_b_addr", 32'(b_rom_addr), 32'd6450);
    vsync = 1'b0;
    tick();
    vsync = 1'b1;
    chk("commit_a_pend", 32'(a_pend), 32'd0);
    tick();
    chk("new_org_a_addr", 32'(a_rom_addr), 32'd0);
    chk("new_org_b_addr", 32'(b_rom_addr), 32'd0);
    tick(); tick();
    chk("new_org_a_pix", 32'(a_pix), 32'h000000);
    chk("new_org_a_hit", 32'(a_hit), 32'd1);
    h_addr = 10'd99;
    repeat (3) tick();
    chk("left_edge_a_hit", 32'(a_hit), 32'd0);
    $display("origin seq: a_pend=%0d a_hit=%0d", a_pend, a_hit);

    // Load coinciding with the vsync fall commits immediately with nothing left pending.
    vsync = 1'b0; pos_load = 1'b1; pos_x = 10'd600; pos_y = 10'd0;
    tick();
    vsync = 1'b1; pos_load = 1'b0;
    chk("coinc_a_pend", 32'(a_pend), 32'd0);
    chk("coinc_b_pend", 32'(b_pend), 32'd0);
    h_addr = 10'd603; v_addr = 10'd3;
    tick();
    chk("scale_a_addr", 32'(a_rom_addr), 32'd771);
    chk("scale_b_addr", 32'(b_rom_addr), 32'd257);
    tick(); tick();
    chk("scale_a_pix", 32'(a_pix), 32'h330033);
    tick();
    chk("scale_b_pix", 32'(b_pix), 32'h002008);
    chk("scale_b_hit", 32'(b_hit), 32'd1);
    h_addr = 10'd599;
    repeat (4) tick();
    chk("clip_b_hit", 32'(b_hit), 32'd0);
    chk("clip_b_pix", 32'(b_pix), 32'h123456);
    chk("clip_a_hit", 32'(a_hit), 32'd0);
    $display("clip seq: b_addr=%0d b_pix=%h b_hit=%0d", b_rom_addr, b_pix, b_hit);

    // Back-to-back pixels, one per cycle, origin (600,0).
    for (int c = 0; c < 6; c++) begin
      h_addr = (c < 4) ? 10'(600 + c) : 10'd0;
      v_addr = 10'd0;
      tick();
      chk("stream_a_addr", 32'(a_rom_addr), (c < 4) ? 32'(c) : 32'd0);
      if (c >= 2) begin
        chk("stream_a_pix", 32'(a_pix), 32'(sp[c-2]));
        chk("stream_a_hit", 32'(a_hit), 32'd1);
      end
      $display("stream c=%0d a_addr=%0d a_pix=%h a_hit=%0d", c, a_rom_addr, a_pix, a_hit);
    end

    // Reset mid-frame with a load pending and image pixels in flight.
    pos_x = 10'd10; pos_y = 10'd10; pos_load = 1'b1;
    tick();
    pos_load = 1'b0;
    h_addr = 10'd601; v_addr = 10'd1;
    repeat (3) tick();
    chk("pre_rst_a_pix", 32'(a_pix), 32'h110011);
    chk("pre_rst_a_pend", 32'(a_pend), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_a_pix",  32'(a_pix), 32'h000000);
    chk("mid_rst_a_hit",  32'(a_hit), 32'd0);
    chk("mid_rst_a_addr", 32'(a_rom_addr), 32'd0);
    chk("mid_rst_a_pend", 32'(a_pend), 32'd0);
    chk("mid_rst_b_pix",  32'(b_pix), 32'h123456);
    tick();
    reset = 1'b1;
    h_addr = 10'd5; v_addr = 10'd2;
    tick();
    chk("post_rst_a_addr", 32'(a_rom_addr), 32'd517);
    vsync = 1'b0;
    tick();
    vsync = 1'b1;
    tick();
    chk("post_rst_frame_a_addr", 32'(a_rom_addr), 32'd517);
    chk("post_rst_a_pend", 32'(a_pend), 32'd0);
    $display("reset seq: a_addr=%0d a_pend=%0d", a_rom_addr, a_pend);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
